// File: rtl/aes_decipher_block_pkg.sv
// Shared definitions for the iterative AES inverse cipher: state encoding, key-length codes,
// the inverse S-box table and the GF(2^8) helpers used by InvMixColumns.
package aes_decipher_block_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_SBOX = 2'd2,
        ST_MAIN = 2'd3
    } dec_state_e;

    localparam logic [1:0] KEYLEN_128 = 2'd0;
    localparam logic [1:0] KEYLEN_192 = 2'd1;
    localparam logic [1:0] KEYLEN_256 = 2'd2;

    localparam logic [3:0] NR_128 = 4'ha;
    localparam logic [3:0] NR_192 = 4'hc;
    localparam logic [3:0] NR_256 = 4'he;

    // Row-major FIPS-197 inverse S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Code 3 is not a legal key length and falls back to the 10-round schedule.
    function automatic logic [3:0] num_rounds(input logic [1:0] kl);
        case (kl)
            KEYLEN_192: return NR_192;
            KEYLEN_256: return NR_256;
            KEYLEN_128: return NR_128;
            default:    return NR_128;
        endcase
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm4(input logic [7:0] b);
        return gm2(gm2(b));
    endfunction

    function automatic logic [7:0] gm8(input logic [7:0] b);
        return gm2(gm4(b));
    endfunction

    function automatic logic [7:0] gm09(input logic [7:0] b);
        return gm8(b) ^ b;
    endfunction

    function automatic logic [7:0] gm0b(input logic [7:0] b);
        return gm8(b) ^ gm2(b) ^ b;
    endfunction

    function automatic logic [7:0] gm0d(input logic [7:0] b);
        return gm8(b) ^ gm4(b) ^ b;
    endfunction

    function automatic logic [7:0] gm0e(input logic [7:0] b);
        return gm8(b) ^ gm4(b) ^ gm2(b);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {gm0e(a0) ^ gm0b(a1) ^ gm0d(a2) ^ gm09(a3),
                gm09(a0) ^ gm0e(a1) ^ gm0b(a2) ^ gm0d(a3),
                gm0d(a0) ^ gm09(a1) ^ gm0e(a2) ^ gm0b(a3),
                gm0b(a0) ^ gm0d(a1) ^ gm09(a2) ^ gm0e(a3)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_column(s[127:96]), inv_mix_column(s[95:64]),
                inv_mix_column(s[63:32]),  inv_mix_column(s[31:0])};
    endfunction

    // Row r of the column-major state rotates right by r byte positions.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        return {s[127:120], s[23:16],   s[47:40],   s[71:64],
                s[95:88],   s[119:112], s[15:8],    s[39:32],
                s[63:56],   s[87:80],   s[111:104], s[7:0],
                s[31:24],   s[55:48],   s[79:72],   s[103:96]};
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse SubWord: four parallel inverse S-box lookups on one 32-bit state word.
module aes_inv_sbox
    import aes_decipher_block_pkg::*;
(
    input  logic [31:0] sword,
    output logic [31:0] new_sword
);

    assign new_sword = {inv_sbox(sword[31:24]), inv_sbox(sword[23:16]),
                        inv_sbox(sword[15:8]),  inv_sbox(sword[7:0])};

endmodule

// File: rtl/aes_decipher_block.sv
// Iterative AES InvCipher: one round per five clocks, the inverse S-box shared across the
// four state words; round keys are fetched from external key memory via round/round_key.
module aes_decipher_block
    import aes_decipher_block_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic [1:0]   keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    dec_state_e   state_q, state_d;
    logic         ready_q, ready_d;
    logic [1:0]   keylen_q, keylen_d;
    logic [3:0]   round_q, round_d;
    logic [1:0]   sword_ctr_q, sword_ctr_d;
    logic [127:0] st_q, st_d;
    logic [31:0]  sword;
    logic [31:0]  new_sword;
    logic         start;

    assign start = (state_q == ST_IDLE) && next;

    always_comb begin
        sword = st_q[127:96];
        case (sword_ctr_q)
            2'd0:    sword = st_q[127:96];
            2'd1:    sword = st_q[95:64];
            2'd2:    sword = st_q[63:32];
            default: sword = st_q[31:0];
        endcase
    end

    aes_inv_sbox u_inv_sbox (
        .sword     (sword),
        .new_sword (new_sword)
    );

    // Round datapath: the last MAIN pass only adds key 0, earlier ones also unmix and unshift.
    always_comb begin
        st_d = st_q;
        case (state_q)
            ST_INIT: st_d = inv_shift_rows(block ^ round_key);
            ST_SBOX: begin
                case (sword_ctr_q)
                    2'd0:    st_d[127:96] = new_sword;
                    2'd1:    st_d[95:64]  = new_sword;
                    2'd2:    st_d[63:32]  = new_sword;
                    default: st_d[31:0]   = new_sword;
                endcase
            end
            ST_MAIN: begin
                if (round_q == 4'd0) begin
                    st_d = st_q ^ round_key;
                end else begin
                    st_d = inv_shift_rows(inv_mix_columns(st_q ^ round_key));
                end
            end
            default: st_d = st_q;
        endcase
    end

    always_comb begin
        sword_ctr_d = sword_ctr_q;
        case (state_q)
            ST_INIT: sword_ctr_d = 2'd0;
            ST_SBOX: sword_ctr_d = sword_ctr_q + 2'd1;
            ST_MAIN: sword_ctr_d = 2'd0;
            default: sword_ctr_d = sword_ctr_q;
        endcase
    end

    // The requested key index counts down Nr..0 and parks at 0 once the run completes.
    always_comb begin
        round_d = round_q;
        case (state_q)
            ST_IDLE: if (start) round_d = num_rounds(keylen);
            ST_INIT: round_d = round_q - 4'd1;
            ST_MAIN: if (round_q != 4'd0) round_d = round_q - 4'd1;
            default: round_d = round_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        keylen_d = keylen_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ready_d  = 1'b0;
                    keylen_d = keylen;
                    state_d  = ST_INIT;
                end
            end
            ST_INIT: state_d = ST_SBOX;
            ST_SBOX: if (sword_ctr_q == 2'd3) state_d = ST_MAIN;
            ST_MAIN: begin
                if (round_q == 4'd0) begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SBOX;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            round_q <= 4'd0;
        end else begin
            round_q <= round_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sword_ctr_q <= 2'd0;
        end else begin
            sword_ctr_q <= sword_ctr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            keylen_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            keylen_q <= keylen_d;
        end
    end

    assign round     = round_q;
    assign new_block = st_q;
    assign ready     = ready_q;

endmodule
